// File: rtl/spi_slave_ram_if.sv
// -----------------------------------------------------------------------------
// spi_slave_ram_if
//   SPI slave front-end for a single-port RAM. A frame is 2 opcode bits
//   followed by DATA_WIDTH payload bits, MSB first, sampled on clk while SS_n
//   is low. Each complete frame is presented on rx_data with a one-cycle
//   rx_valid pulse. After a read-data frame (opcode 2'b11, issued once a
//   read-address frame has been seen) the block waits up to MAX_WAIT cycles
//   for tx_valid, then shifts the captured tx_data out on MISO, MSB first.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   SS_n          in   slave select, active low; high ends or aborts a frame
//   MOSI          in   serial data in
//   MISO          out  serial data out, 0 outside TX
//   rx_data       out  last complete frame {opcode, payload}
//   rx_valid      out  one-cycle pulse when rx_data is updated
//   tx_data       in   RAM read data
//   tx_valid      in   tx_data valid (only looked at while waiting for it)
//   busy          out  state is not IDLE
//   frame_err     out  one-cycle pulse on abort or read-data timeout
//   rd_addr_seen  out  read address received, read data not yet sent
// -----------------------------------------------------------------------------
module spi_slave_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  rd_addr_seen
);

  localparam int DW     = DATA_WIDTH;
  localparam int CNT_W  = $clog2(DATA_WIDTH + 2);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    TX,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DW:0]          shift_q, shift_d;      // frame bits received so far
  logic [CNT_W-1:0]     cnt_q, cnt_d;          // bit counter (receive and transmit)
  logic [WAIT_W-1:0]    wait_q, wait_d;        // cycles spent waiting for tx_valid
  logic [DW-1:0]        tx_shift_q, tx_shift_d;
  logic [DW+1:0]        rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 miso_q, miso_d;
  logic                 seen_q, seen_d;

  logic [1:0]           opcode;
  logic                 last_bit;
  logic                 abortable;

  // Opcode sits in the two oldest bits of the shift register on the last-bit edge.
  assign opcode    = shift_q[DW:DW-1];
  assign last_bit  = (cnt_q == CNT_W'(DW));
  assign abortable = (state_q != IDLE) && (state_q != DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      seen_q      <= seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = 1'b0;
    seen_d      = seen_q;

    // SS_n high mid-transaction wins over everything, including a last-bit
    // edge, so a frame cut short on its final bit is discarded.
    if (SS_n && abortable) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      cnt_d       = '0;
      wait_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!SS_n) begin
            state_d = CHK_CMD;
            cnt_d   = '0;
          end
        end

        CHK_CMD: begin
          shift_d = {{DW{1'b0}}, MOSI};
          cnt_d   = '0;
          if (!MOSI)        state_d = WRITE;
          else if (!seen_q) state_d = READ_ADD;
          else              state_d = READ_DATA;
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (last_bit) begin
            rx_data_d  = {shift_q, MOSI};
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = DONE;
            if (state_q == READ_ADD && opcode == 2'b10) begin
              seen_d = 1'b1;
            end
            if (state_q == READ_DATA && opcode == 2'b11) begin
              state_d = WAIT_TX;
              wait_d  = '0;
            end
          end else begin
            shift_d = {shift_q[DW-1:0], MOSI};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end

        WAIT_TX: begin
          // Data arriving on the expiry cycle is still accepted.
          if (tx_valid) begin
            miso_d     = tx_data[DW-1];
            tx_shift_d = tx_data << 1;
            cnt_d      = '0;
            wait_d     = '0;
            state_d    = TX;
          end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
            frame_err_d = 1'b1;
            wait_d      = '0;
            state_d     = DONE;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end

        TX: begin
          // MISO is registered: the MSB went out on the capture edge, so
          // each TX edge presents the next bit until DW bits have been shown.
          if (cnt_q == CNT_W'(DW - 1)) begin
            seen_d  = 1'b0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            miso_d     = tx_shift_q[DW-1];
            tx_shift_d = tx_shift_q << 1;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          if (SS_n) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign MISO         = miso_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_err    = frame_err_q;
  assign rd_addr_seen = seen_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_ram_if.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ram_if
//   Bench for spi_slave_ram_if: an 8-bit instance driven by a table of frames
//   plus hand-written read/timeout/abort sequences, and a 16-bit instance for
//   the wide-frame and mid-frame reset cases. Received frames are checked by
//   a scoreboard queue per instance.
// -----------------------------------------------------------------------------
module tb_spi_slave_ram_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        ss_n8 = 1'b1, mosi8 = 1'b0, miso8;
  logic [9:0]  rx_data8;
  logic        rx_valid8, busy8, frame_err8, seen8;
  logic [7:0]  tx_data8 = 8'h00;
  logic        tx_valid8 = 1'b0;

  logic        ss_n16 = 1'b1, mosi16 = 1'b0, miso16;
  logic [17:0] rx_data16;
  logic        rx_valid16, busy16, frame_err16, seen16;
  logic [15:0] tx_data16 = 16'h0000;
  logic        tx_valid16 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0]  exp_rx8[$];
  logic [17:0] exp_rx16[$];
  logic        exp_miso[$];
  logic [9:0]  last_rx8 = 10'h000;

  always #5 clk = ~clk;

  spi_slave_ram_if #(.DATA_WIDTH(8), .MAX_WAIT(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n8), .MOSI(mosi8), .MISO(miso8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_data(tx_data8), .tx_valid(tx_valid8),
    .busy(busy8), .frame_err(frame_err8), .rd_addr_seen(seen8)
  );

  spi_slave_ram_if #(.DATA_WIDTH(16), .MAX_WAIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n16), .MOSI(mosi16), .MISO(miso16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16), .tx_valid(tx_valid16),
    .busy(busy16), .frame_err(frame_err16), .rd_addr_seen(seen16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: every rx_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && rx_valid8) begin
      if (exp_rx8.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx8_unexpected: got frame %0h, expected none", rx_data8);
      end else begin
        chk("rx8_data", 32'(rx_data8), 32'(exp_rx8.pop_front()));
      end
    end
    if (rst_n && rx_valid16) begin
      if (exp_rx16.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx16_unexpected: got frame %0h, expected none", rx_data16);
      end else begin
        chk("rx16_data", 32'(rx_data16), 32'(exp_rx16.pop_front()));
      end
    end
  end

  // Sends a 10-bit frame to the 8-bit instance. abort_bit >= 0 raises SS_n on
  // that bit's edge. hold keeps SS_n low afterwards (for read-data frames).
  task automatic send_frame(input logic [9:0] f, input int abort_bit, input bit hold,
                            output int valid_at, output int n_valid,
                            output int n_ferr, output int n_miso);
    valid_at = -1;
    n_valid  = 0;
    n_ferr   = 0;
    n_miso   = 0;
    ss_n8 = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      mosi8 = f[9-i];
      if (i == abort_bit) ss_n8 = 1'b1;
      step();
      if (rx_valid8) begin
        n_valid++;
        if (valid_at < 0) valid_at = i;
      end
      if (frame_err8) n_ferr++;
      if (miso8) n_miso++;
      if (i == abort_bit) begin
        chk("abort_busy", 32'(busy8), 32'd0);
        break;
      end
    end
    mosi8 = 1'b0;
    if (!hold) begin
      ss_n8 = 1'b1;
      step();
      if (rx_valid8) n_valid++;
      if (frame_err8) n_ferr++;
      if (miso8) n_miso++;
    end
  endtask

  // Pops expected MISO bits one per cycle, then expects MISO back at 0.
  task automatic check_miso_stream(input string name);
    while (exp_miso.size() > 0) begin
      chk(name, 32'(miso8), 32'(exp_miso.pop_front()));
      step();
    end
    chk({name, "_end"}, 32'(miso8), 32'd0);
  endtask

  task automatic push_tx(input logic [7:0] d);
    for (int k = 7; k >= 0; k--) exp_miso.push_back(d[k]);
  endtask

  typedef struct {
    logic [9:0] frame;
    int         abort_bit;
    logic       exp_valid;
    logic       exp_seen;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int va, nv, nf, nm, first_err;

    tbl[0] = '{10'h05A, -1, 1'b1, 1'b0};  // write
    tbl[1] = '{10'h1A5, -1, 1'b1, 1'b0};  // write, opcode 01
    tbl[2] = '{10'h3FF, -1, 1'b1, 1'b0};  // opcode MSB 1, no address yet -> READ_ADD
    tbl[3] = '{10'h0C3,  5, 1'b0, 1'b0};  // abort after 5 bits
    tbl[4] = '{10'h233, -1, 1'b1, 1'b1};  // read address
    tbl[5] = '{10'h012, -1, 1'b1, 1'b1};  // write while address pending
    tbl[6] = '{10'h244, -1, 1'b1, 1'b1};  // opcode 10 in READ_DATA -> no TX
    tbl[7] = '{10'h177,  9, 1'b0, 1'b1};  // SS_n rises on the last-bit edge

    // Reset
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset_rx_data", 32'(rx_data8), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid8), 32'd0);
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_frame_err", 32'(frame_err8), 32'd0);
    chk("reset_seen", 32'(seen8), 32'd0);
    chk("reset_miso", 32'(miso8), 32'd0);

    // Table of frames
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].exp_valid) begin
        exp_rx8.push_back(tbl[t].frame);
        last_rx8 = tbl[t].frame;
      end
      send_frame(tbl[t].frame, tbl[t].abort_bit, 1'b0, va, nv, nf, nm);
      $display("vec %0d: frame=%03h abort=%0d valid_at=%0d ferr=%0d seen=%0b rx_data=%03h",
               t, tbl[t].frame, tbl[t].abort_bit, va, nf, seen8, rx_data8);
      chk("tbl_valid_count", 32'(nv), 32'(tbl[t].exp_valid));
      if (tbl[t].exp_valid) chk("tbl_valid_at", 32'(va), 32'd9);
      chk("tbl_ferr_count", 32'(nf), (tbl[t].abort_bit >= 0) ? 32'd1 : 32'd0);
      chk("tbl_miso_quiet", 32'(nm), 32'd0);
      chk("tbl_seen", 32'(seen8), 32'(tbl[t].exp_seen));
      chk("tbl_rx_hold", 32'(rx_data8), 32'(last_rx8));
      chk("tbl_idle", 32'(busy8), 32'd0);
    end

    // Read data with tx_valid three cycles after the frame
    exp_rx8.push_back(10'h300);
    last_rx8 = 10'h300;
    send_frame(10'h300, -1, 1'b1, va, nv, nf, nm);
    chk("rd_valid_at", 32'(va), 32'd9);
    chk("rd_wait_busy", 32'(busy8), 32'd1);
    step();
    step();
    chk("rd_wait_miso", 32'(miso8), 32'd0);
    tx_valid8 = 1'b1;
    tx_data8  = 8'hC3;
    push_tx(8'hC3);
    step();
    tx_valid8 = 1'b0;
    tx_data8  = 8'h00;
    check_miso_stream("rd_miso");
    chk("rd_seen_cleared", 32'(seen8), 32'd0);
    ss_n8 = 1'b1;
    step();
    chk("rd_idle", 32'(busy8), 32'd0);
    $display("seq read: tx=C3 seen=%0b", seen8);

    // Timeout with tx_valid withheld, then retry
    exp_rx8.push_back(10'h255);
    send_frame(10'h255, -1, 1'b0, va, nv, nf, nm);
    chk("to_seen_set", 32'(seen8), 32'd1);
    exp_rx8.push_back(10'h300);
    send_frame(10'h300, -1, 1'b1, va, nv, nf, nm);
    first_err = -1;
    nm = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (frame_err8 && first_err < 0) first_err = c;
      if (miso8) nm++;
    end
    chk("to_err_cycle", 32'(first_err), 32'd16);
    chk("to_miso_quiet", 32'(nm), 32'd0);
    chk("to_seen_kept", 32'(seen8), 32'd1);
    ss_n8 = 1'b1;
    step();
    $display("seq timeout: err_cycle=%0d seen=%0b", first_err, seen8);
    exp_rx8.push_back(10'h300);
    last_rx8 = 10'h300;
    send_frame(10'h300, -1, 1'b1, va, nv, nf, nm);
    tx_valid8 = 1'b1;
    tx_data8  = 8'h96;
    push_tx(8'h96);
    step();
    tx_valid8 = 1'b0;
    check_miso_stream("retry_miso");
    chk("retry_seen_cleared", 32'(seen8), 32'd0);
    ss_n8 = 1'b1;
    step();

    // tx_valid on the same edge as timeout expiry is accepted
    exp_rx8.push_back(10'h266);
    send_frame(10'h266, -1, 1'b0, va, nv, nf, nm);
    exp_rx8.push_back(10'h300);
    last_rx8 = 10'h300;
    send_frame(10'h300, -1, 1'b1, va, nv, nf, nm);
    nf = 0;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (frame_err8) nf++;
    end
    tx_valid8 = 1'b1;
    tx_data8  = 8'hA7;
    push_tx(8'hA7);
    step();
    tx_valid8 = 1'b0;
    if (frame_err8) nf++;
    chk("coinc_no_err", 32'(nf), 32'd0);
    check_miso_stream("coinc_miso");
    chk("coinc_seen_cleared", 32'(seen8), 32'd0);
    ss_n8 = 1'b1;
    step();
    $display("seq coincident: ferr=%0d seen=%0b", nf, seen8);

    // tx_valid outside WAIT_TX is ignored
    tx_valid8 = 1'b1;
    tx_data8  = 8'hFF;
    step();
    step();
    tx_valid8 = 1'b0;
    chk("stray_tx_busy", 32'(busy8), 32'd0);
    chk("stray_tx_miso", 32'(miso8), 32'd0);

    // Abort during TX keeps rd_addr_seen for a retry
    exp_rx8.push_back(10'h299);
    send_frame(10'h299, -1, 1'b0, va, nv, nf, nm);
    exp_rx8.push_back(10'h301);
    last_rx8 = 10'h301;
    send_frame(10'h301, -1, 1'b1, va, nv, nf, nm);
    tx_valid8 = 1'b1;
    tx_data8  = 8'hFF;
    step();
    tx_valid8 = 1'b0;
    chk("txab_first_bit", 32'(miso8), 32'd1);
    step();
    step();
    ss_n8 = 1'b1;
    step();
    chk("txab_ferr", 32'(frame_err8), 32'd1);
    chk("txab_miso", 32'(miso8), 32'd0);
    chk("txab_busy", 32'(busy8), 32'd0);
    chk("txab_seen_kept", 32'(seen8), 32'd1);
    step();
    chk("txab_ferr_pulse", 32'(frame_err8), 32'd0);
    $display("seq tx abort: seen=%0b", seen8);

    // 16-bit instance: frame 01_BEEF
    exp_rx16.push_back(18'h1BEEF);
    begin
      logic [17:0] f16;
      f16 = 18'h1BEEF;
      va = -1;
      nv = 0;
      ss_n16 = 1'b0;
      step();
      for (int i = 0; i < 18; i++) begin
        mosi16 = f16[17-i];
        step();
        if (rx_valid16) begin
          nv++;
          if (va < 0) va = i;
        end
      end
      ss_n16 = 1'b1;
      step();
      if (rx_valid16) nv++;
    end
    chk("w16_valid_at", 32'(va), 32'd17);
    chk("w16_valid_count", 32'(nv), 32'd1);
    chk("w16_rx_data", 32'(rx_data16), 32'h1BEEF);
    $display("seq wide: rx_data16=%05h valid_at=%0d", rx_data16, va);

    // Reset in the middle of a 16-bit frame
    ss_n16 = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      mosi16 = i[0];
      step();
    end
    chk("mid_busy_before", 32'(busy16), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst_rx16", 32'(rx_data16), 32'd0);
    chk("rst_valid16", 32'(rx_valid16), 32'd0);
    chk("rst_ferr16", 32'(frame_err16), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_seen8", 32'(seen8), 32'd0);
    chk("rst_rx8", 32'(rx_data8), 32'd0);
    rst_n  = 1'b1;
    ss_n16 = 1'b1;
    mosi16 = 1'b0;
    step();
    chk("post_rst_busy16", 32'(busy16), 32'd0);
    chk("post_rst_ferr16", 32'(frame_err16), 32'd0);
    $display("seq reset: rx16=%05h busy16=%0b", rx_data16, busy16);

    step();
    chk("sb8_drained", 32'(exp_rx8.size()), 32'd0);
    chk("sb16_drained", 32'(exp_rx16.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
